mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Controller for the 4th (memory) pipeline stage.
//  - Decodes the stage-4 instruction (ir4) and drives the stage mux selects: select_z5 and select_writedata.
//  - Sequences the data-memory req/ack handshake and stalls the pipeline while an access is outstanding.
//  - Gates the z5/ir5 pipeline-register load and times out hung accesses.
//  Sits beside the memory-stage datapath; its outputs drive the datapath mux selects, the data memory and the hazard/stall logic.
// PARAMETERS
//  TIMEOUT_CYCLES  16  cycles in ACCESS without mem_ack before abort (>=2)
//  CNT_W           5   timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clk               in   1   pipeline clock, rising edge
//  reset             in   1   synchronous, active-high
//  ir4               in   32  instruction in stage 4
//  valid4            in   1   ir4 holds a real instruction (not a bubble)
//  ir5               in   32  instruction in stage 5 (for store-data forwarding)
//  valid5            in   1   ir5 holds a real instruction
//  mem_ack           in   1   data memory done; read_data valid in the same cycle
//  select_z5         out  2   0=read_data 1=z4 2=pc4 (3 never driven)
//  select_writedata  out  1   0=z5 (forwarded) 1=md4
//  mem_req           out  1   access request, held until ack or abort
//  mem_we            out  1   1=store, 0=load; valid only while mem_req=1
//  stall             out  1   freeze stages 1-4 this cycle
//  z5_en             out  1   load z5/ir5 pipeline registers this cycle
//  kill5             out  1   load a bubble into stage 5 (qualifies z5_en)
//  mem_err           out  1   sticky timeout flag
// BEHAVIOUR
//  Decode (shared pkg): opcode=ir[31:26]; LOAD=6'h23, STORE=6'h2B, JAL=6'h03, RTYPE=6'h00.
//   Fields: rt=ir[20:16], rd=ir[15:11].
//   Destination reg: RTYPE->rd; JAL->31; other non-STORE->rt; STORE->none.
//  select_z5 (combinational from ir4): LOAD->0, JAL->2, otherwise->1.
//  select_writedata (combinational): 0 when all hold, else 1:
//   valid5 && ir5 writes a reg && dest5!=0 && dest5==rt(ir4) && ir4 is STORE.
//  mem_op = valid4 && (LOAD || STORE).
//  FSM states: IDLE, ACCESS, ERROR.
//   IDLE, !mem_op: stall=0, z5_en=1, kill5=~valid4; stay.
//   IDLE, mem_op: stall=1, z5_en=0; next=ACCESS, cnt<=0.
//   ACCESS: mem_req=1, mem_we=STORE(ir4), stall=1, z5_en=0, cnt++.
//    mem_ack: stall=0, z5_en=1, kill5=0; next=IDLE. Load data is captured this same cycle.
//    else cnt==TIMEOUT_CYCLES-1: next=ERROR; mem_err<=1.
//    ack and timeout in the same cycle: ack wins, no error.
//   ERROR (one cycle): mem_req=0, stall=0, z5_en=1, kill5=1 (instruction dropped); next=IDLE.
//  Latency: non-mem op 0 stall cycles. Mem op 1 + N stall cycles, where N = cycles from mem_req high to ack (N>=1).
//  mem_req/mem_we/stall/z5_en/kill5 are decoded from state + inputs; mem_req never asserts in IDLE.
//  mem_ack outside ACCESS: ignored.
//  mem_err: sticky until reset.
//  Reset values: state=IDLE, cnt=0, mem_err=0.
//   Hence mem_req=0 and mem_we=0 in the cycle after reset.
//   Reset asserted mid-ACCESS drops mem_req on the next edge; no ack is awaited.
//  ir4/valid4 are held stable by stall; the controller does not re-latch them.
// STRUCTURE
//  Shared pkg: opcode constants, field bit positions, dest_reg() function, FSM state encoding, select_z5 encodings.
//  Sub-module: mem_timeout_counter (clear, enable, terminal-count out, TIMEOUT_CYCLES param).
//  FSM, decode and forwarding compare stay in mem_access_ctrl.
// TESTING
//  1) ALU ir4=RTYPE valid4=1 -> select_z5=1, stall=0, z5_en=1, mem_req never 1.
//  2) LOAD, mem_ack 3 cycles after mem_req rises:
//     -> stall high 4 cycles, mem_we=0, select_z5=0, z5_en=1 exactly on the ack cycle.
//  3) STORE rt=5, ir5=RTYPE rd=5 valid5=1 -> select_writedata=0, mem_we=1.
//     Same with rd=0 or valid5=0 -> select_writedata=1.
//  4) LOAD, no ack, TIMEOUT_CYCLES=4:
//     -> mem_req high 4 cycles, then ERROR cycle: kill5=1, z5_en=1, mem_err=1.
//     mem_err stays 1 until reset.
//  5) Ack on the terminal timeout cycle -> normal completion, mem_err=0.
//  6) reset=1 during ACCESS -> next cycle mem_req=0, stall=0, mem_err=0.
//     A late mem_ack in IDLE has no effect.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared decode for the memory-stage controller: opcodes, instruction fields,
// destination-register lookup, FSM state and z5 mux encodings.
package mem_access_ctrl_pkg;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpLoad  = 6'h23;
    localparam logic [5:0] OpStore = 6'h2B;

    localparam int unsigned OpcodeMsb = 31;
    localparam int unsigned OpcodeLsb = 26;
    localparam int unsigned RtMsb     = 20;
    localparam int unsigned RtLsb     = 16;
    localparam int unsigned RdMsb     = 15;
    localparam int unsigned RdLsb     = 11;

    localparam logic [4:0] LinkReg = 5'd31;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StError
    } state_e;

    typedef enum logic [1:0] {
        SelZ5ReadData = 2'd0,
        SelZ5Z4       = 2'd1,
        SelZ5Pc4      = 2'd2
    } sel_z5_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] idx;
    } dest_t;

    function automatic logic [5:0] opcode(input logic [31:0] ir);
        return ir[OpcodeMsb:OpcodeLsb];
    endfunction

    function automatic logic [4:0] rt(input logic [31:0] ir);
        return ir[RtMsb:RtLsb];
    endfunction

    function automatic logic [4:0] rd(input logic [31:0] ir);
        return ir[RdMsb:RdLsb];
    endfunction

    function automatic dest_t dest_reg(input logic [31:0] ir);
        dest_t d;
        d.valid = 1'b1;
        unique case (opcode(ir))
            OpRtype: d.idx = rd(ir);
            OpJal:   d.idx = LinkReg;
            OpStore: begin
                d.valid = 1'b0;
                d.idx   = '0;
            end
            default: d.idx = rt(ir);
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_timeout.sv
// Timeout counter for an outstanding data-memory access; tc_o flags the last
// cycle the access may still complete without being aborted.
module mem_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: decodes ir4 into mux selects, runs the data-memory
// req/ack handshake, stalls the front of the pipe and aborts hung accesses.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] ir4_i,
    input  logic        valid4_i,
    input  logic [31:0] ir5_i,
    input  logic        valid5_i,
    input  logic        mem_ack_i,
    output logic [1:0]  select_z5_o,
    output logic        select_writedata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        stall_o,
    output logic        z5_en_o,
    output logic        kill5_o,
    output logic        mem_err_o
);

    state_e state_q, state_d;
    logic   mem_err_q, mem_err_d;
    logic   cnt_clear, cnt_en, cnt_tc;
    logic   is_load4, is_store4, mem_op;
    dest_t  dest5;
    logic   unused_ir_bits;

    assign unused_ir_bits = ^{ir4_i[25:21], ir4_i[10:0], ir5_i[25:21], ir5_i[10:0]};

    assign is_load4  = (opcode(ir4_i) == OpLoad);
    assign is_store4 = (opcode(ir4_i) == OpStore);
    assign mem_op    = valid4_i && (is_load4 || is_store4);
    assign dest5     = dest_reg(ir5_i);

    always_comb begin
        sel_z5_e sel;
        if (is_load4) begin
            sel = SelZ5ReadData;
        end else if (opcode(ir4_i) == OpJal) begin
            sel = SelZ5Pc4;
        end else begin
            sel = SelZ5Z4;
        end
        select_z5_o = sel;
    end

    // Forward z5 as store data when the stage-5 result targets the store's rt.
    assign select_writedata_o = ~(valid5_i && dest5.valid && (dest5.idx != 5'd0) &&
                                  (dest5.idx == rt(ir4_i)) && is_store4);

    mem_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timeout (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(cnt_clear),
        .en_i   (cnt_en),
        .tc_o   (cnt_tc)
    );

    always_comb begin
        state_d   = state_q;
        mem_err_d = mem_err_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        mem_req_o = 1'b0;
        stall_o   = 1'b0;
        z5_en_o   = 1'b0;
        kill5_o   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_op) begin
                    stall_o   = 1'b1;
                    cnt_clear = 1'b1;
                    state_d   = StAccess;
                end else begin
                    z5_en_o = 1'b1;
                    kill5_o = ~valid4_i;
                end
            end
            StAccess: begin
                mem_req_o = 1'b1;
                cnt_en    = 1'b1;
                // Ack takes priority over a timeout landing in the same cycle.
                if (mem_ack_i) begin
                    z5_en_o = 1'b1;
                    state_d = StIdle;
                end else begin
                    stall_o = 1'b1;
                    if (cnt_tc) begin
                        state_d   = StError;
                        mem_err_d = 1'b1;
                    end
                end
            end
            StError: begin
                z5_en_o = 1'b1;
                kill5_o = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign mem_we_o  = mem_req_o && is_store4;
    assign mem_err_o = mem_err_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_err_q <= mem_err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a short timeout; expected output
// vectors go through a scoreboard queue and are checked mid-cycle.
module tb_mem_access_ctrl;

    localparam logic [5:0] OP_R = 6'h00;
    localparam logic [5:0] OP_J = 6'h03;
    localparam logic [5:0] OP_L = 6'h23;
    localparam logic [5:0] OP_S = 6'h2B;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ir4, ir5;
    logic        valid4, valid5, mem_ack;
    logic [1:0]  select_z5;
    logic        select_writedata, mem_req, mem_we, stall, z5_en, kill5, mem_err;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];
    logic [8:0] obs, exp_v;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .TIMEOUT_CYCLES(4),
        .CNT_W         (5)
    ) dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .ir4_i             (ir4),
        .valid4_i          (valid4),
        .ir5_i             (ir5),
        .valid5_i          (valid5),
        .mem_ack_i         (mem_ack),
        .select_z5_o       (select_z5),
        .select_writedata_o(select_writedata),
        .mem_req_o         (mem_req),
        .mem_we_o          (mem_we),
        .stall_o           (stall),
        .z5_en_o           (z5_en),
        .kill5_o           (kill5),
        .mem_err_o         (mem_err)
    );

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rt,
                                       input logic [4:0] rd);
        return {op, 5'd1, rt, rd, 11'd0};
    endfunction

    // {select_z5, select_writedata, mem_req, mem_we, stall, z5_en, kill5, mem_err}
    function automatic logic [8:0] ex(input logic [1:0] sz, input logic wd, input logic req,
                                      input logic we, input logic st, input logic en,
                                      input logic kl, input logic er);
        return {sz, wd, req, we, st, en, kl, er};
    endfunction

    task automatic step(input string tag, input logic [8:0] e);
        exp_q.push_back(e);
        @(negedge clk);
        obs   = {select_z5, select_writedata, mem_req, mem_we, stall, z5_en, kill5, mem_err};
        exp_v = exp_q.pop_front();
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        ir4     = '0;
        ir5     = '0;
        valid4  = 1'b0;
        valid5  = 1'b0;
        mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        step("reset", ex(2'd1, 1, 0, 0, 0, 1, 1, 0));

        // Non-memory instructions pass straight through.
        ir4 = mk(OP_R, 5'd3, 5'd4); valid4 = 1'b1;
        step("alu", ex(2'd1, 1, 0, 0, 0, 1, 0, 0));
        ir4 = mk(OP_J, 5'd0, 5'd0);
        step("jal", ex(2'd2, 1, 0, 0, 0, 1, 0, 0));

        // Load acked three cycles after mem_req rises (terminal timeout cycle).
        ir4 = mk(OP_L, 5'd2, 5'd0);
        step("ld_idle", ex(2'd0, 1, 0, 0, 1, 0, 0, 0));
        step("ld_a0", ex(2'd0, 1, 1, 0, 1, 0, 0, 0));
        step("ld_a1", ex(2'd0, 1, 1, 0, 1, 0, 0, 0));
        step("ld_a2", ex(2'd0, 1, 1, 0, 1, 0, 0, 0));
        mem_ack = 1'b1;
        step("ld_ack", ex(2'd0, 1, 1, 0, 0, 1, 0, 0));
        mem_ack = 1'b0; ir4 = mk(OP_R, 5'd3, 5'd4);
        step("ld_after", ex(2'd1, 1, 0, 0, 0, 1, 0, 0));

        // Store with forwarded data from an R-type in stage 5.
        ir5 = mk(OP_R, 5'd9, 5'd5); valid5 = 1'b1;
        ir4 = mk(OP_S, 5'd5, 5'd0);
        step("st_idle", ex(2'd1, 0, 0, 0, 1, 0, 0, 0));
        step("st_a0", ex(2'd1, 0, 1, 1, 1, 0, 0, 0));
        mem_ack = 1'b1;
        step("st_ack", ex(2'd1, 0, 1, 1, 0, 1, 0, 0));
        mem_ack = 1'b0; valid4 = 1'b0;
        step("fw_bubble", ex(2'd1, 0, 0, 0, 0, 1, 1, 0));
        ir5 = mk(OP_R, 5'd9, 5'd0);
        step("fw_rd0", ex(2'd1, 1, 0, 0, 0, 1, 1, 0));
        ir5 = mk(OP_R, 5'd9, 5'd5); valid5 = 1'b0;
        step("fw_nvalid5", ex(2'd1, 1, 0, 0, 0, 1, 1, 0));
        ir5 = mk(OP_L, 5'd5, 5'd0); valid5 = 1'b1;
        step("fw_load5", ex(2'd1, 0, 0, 0, 0, 1, 1, 0));
        ir5 = mk(OP_S, 5'd5, 5'd0);
        step("fw_store5", ex(2'd1, 1, 0, 0, 0, 1, 1, 0));
        ir5 = mk(OP_J, 5'd0, 5'd0); ir4 = mk(OP_S, 5'd31, 5'd0);
        step("fw_jal5", ex(2'd1, 0, 0, 0, 0, 1, 1, 0));
        ir5 = mk(OP_R, 5'd9, 5'd5); ir4 = mk(OP_S, 5'd6, 5'd0);
        step("fw_rt_ne", ex(2'd1, 1, 0, 0, 0, 1, 1, 0));
        ir4 = mk(OP_L, 5'd5, 5'd0);
        step("fw_load4", ex(2'd0, 1, 0, 0, 0, 1, 1, 0));
        valid5 = 1'b0;

        // Load that never completes: four request cycles then the abort cycle.
        valid4 = 1'b1;
        step("to_idle", ex(2'd0, 1, 0, 0, 1, 0, 0, 0));
        step("to_a0", ex(2'd0, 1, 1, 0, 1, 0, 0, 0));
        step("to_a1", ex(2'd0, 1, 1, 0, 1, 0, 0, 0));
        step("to_a2", ex(2'd0, 1, 1, 0, 1, 0, 0, 0));
        step("to_a3", ex(2'd0, 1, 1, 0, 1, 0, 0, 0));
        step("to_error", ex(2'd0, 1, 0, 0, 0, 1, 1, 1));
        ir4 = mk(OP_R, 5'd3, 5'd4);
        step("err_sticky", ex(2'd1, 1, 0, 0, 0, 1, 0, 1));
        valid4 = 1'b0;
        step("err_sticky2", ex(2'd1, 1, 0, 0, 0, 1, 1, 1));

        // Reset in the middle of an access.
        ir4 = mk(OP_L, 5'd7, 5'd0); valid4 = 1'b1;
        step("rs_idle", ex(2'd0, 1, 0, 0, 1, 0, 0, 1));
        step("rs_a0", ex(2'd0, 1, 1, 0, 1, 0, 0, 1));
        reset = 1'b1;
        step("rs_assert", ex(2'd0, 1, 1, 0, 1, 0, 0, 1));
        reset = 1'b0; ir4 = mk(OP_R, 5'd3, 5'd4);
        step("rs_after", ex(2'd1, 1, 0, 0, 0, 1, 0, 0));
        mem_ack = 1'b1;
        step("late_ack", ex(2'd1, 1, 0, 0, 0, 1, 0, 0));
        ir4 = mk(OP_L, 5'd7, 5'd0);
        step("ack_idle_ign", ex(2'd0, 1, 0, 0, 1, 0, 0, 0));
        step("ack_first", ex(2'd0, 1, 1, 0, 0, 1, 0, 0));
        mem_ack = 1'b0; ir4 = mk(OP_R, 5'd3, 5'd4);
        step("final", ex(2'd1, 1, 0, 0, 0, 1, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
